vga_timing_gen: RTL and testbench

- Generates VGA 640x480@60 raster timing from the system clock. It directly feeds the frame-buffer readout stage with H_Count_Value / V_Count_Value, a per-pixel enable, and a linear pixel address.
- Drives hsync/vsync to the DAC/connector and exposes video_on, so downstream stages no longer keep private address counters.
- Pixel rate is clk / CLK_DIV, gated by a one-clk pixel tick. All downstream stages advance only on pix_en.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/pixel_tick_div.sv | 33 +++
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants plus a small window-decode helper
// shared by the timing generator and its pixel-tick divider.
package vga_timing_pkg;

   localparam int CLK_DIV  = 2;
   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam bit SYNC_POL = 1'b0;
   localparam int ADDR_W   = 19;

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   localparam int ACTIVE_PIXELS = H_ACTIVE * V_ACTIVE;

   // Inclusive range test on a 10-bit raster count.
   function automatic logic in_window(input logic [9:0] val, input int lo, input int hi);
      return (int'(val) >= lo) && (int'(val) <= hi);
   endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Pixel-rate enable: one registered pulse every CLK_DIV system clocks.
// The first pulse lands CLK_DIV clocks after reset release; with
// CLK_DIV = 1 the output stays high from the first clock onward.
module pixel_tick_div #(
   parameter int CLK_DIV = vga_timing_pkg::CLK_DIV
) (
   input  logic clk,
   input  logic rst_n,
   output logic pix_en
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic             r_pix_en;
   logic             w_last;

   assign w_last = (r_div == DIV_LAST);
   assign pix_en = r_pix_en;

   // Divider wraps at CLK_DIV-1; the enable registers the wrap condition
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div    <= '0;
         r_pix_en <= 1'b0;
      end else begin
         r_div    <= w_last ? '0 : r_div + DIV_W'(1);
         r_pix_en <= w_last;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: H/V counters, sync/active decodes and a linear
// frame-buffer address, all stepping on the pixel enable. Every output is
// registered from the next-state counts, so the decodes always match the
// H/V values shown in the same cycle.
module vga_timing_gen #(
   parameter int CLK_DIV  = vga_timing_pkg::CLK_DIV,
   parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
   parameter int H_FP     = vga_timing_pkg::H_FP,
   parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
   parameter int H_BP     = vga_timing_pkg::H_BP,
   parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
   parameter int V_FP     = vga_timing_pkg::V_FP,
   parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
   parameter int V_BP     = vga_timing_pkg::V_BP,
   parameter bit SYNC_POL = vga_timing_pkg::SYNC_POL,
   parameter int ADDR_W   = vga_timing_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              pix_en,
   output logic [9:0]        H_Count_Value,
   output logic [9:0]        V_Count_Value,
   output logic              hsync,
   output logic              vsync,
   output logic              video_on,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic              frame_start
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC - 1;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC - 1;

   localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

   logic              w_pix_en;
   logic              w_h_last;
   logic              w_v_last;
   logic              w_frame_wrap;
   logic [9:0]        w_h_nxt;
   logic [9:0]        w_v_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;

   logic [9:0]        r_h;
   logic [9:0]        r_v;
   logic              r_hsync;
   logic              r_vsync;
   logic              r_video_on;
   logic [ADDR_W-1:0] r_addr;
   logic              r_frame_start;

   pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix_en (w_pix_en)
   );

   assign w_h_last = (r_h == H_LAST);
   assign w_v_last = (r_v == V_LAST);

   // Next-state for the raster counters and the address counter. The
   // address advances when leaving an active pixel (r_video_on describes
   // the current position), so through blanking it already holds the index
   // of the next visible pixel; a frame wrap clears it.
   always_comb begin
      w_h_nxt      = r_h;
      w_v_nxt      = r_v;
      w_addr_nxt   = r_addr;
      w_frame_wrap = 1'b0;
      if (w_pix_en) begin
         if (w_h_last) begin
            w_h_nxt = '0;
            if (w_v_last) begin
               w_v_nxt      = '0;
               w_frame_wrap = 1'b1;
            end else begin
               w_v_nxt = r_v + 10'd1;
            end
         end else begin
            w_h_nxt = r_h + 10'd1;
         end
         if (w_frame_wrap)
            w_addr_nxt = '0;
         else if (r_video_on)
            w_addr_nxt = r_addr + ADDR_W'(1);
      end
   end

   // Register counts and decode the next-state position for zero skew
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h           <= '0;
         r_v           <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_video_on    <= 1'b1;
         r_addr        <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_h           <= w_h_nxt;
         r_v           <= w_v_nxt;
         r_hsync       <= vga_timing_pkg::in_window(w_h_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
         r_vsync       <= vga_timing_pkg::in_window(w_v_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
         r_video_on    <= (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
         r_addr        <= w_addr_nxt;
         r_frame_start <= w_frame_wrap;
      end
   end

   assign pix_en        = w_pix_en;
   assign H_Count_Value = r_h;
   assign V_Count_Value = r_v;
   assign hsync         = r_hsync;
   assign vsync         = r_vsync;
   assign video_on      = r_video_on;
   assign pixel_addr    = r_addr;
   assign frame_start   = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 build for line-level timing,
// plus two shrunken rasters (16x12, CLK_DIV 2 and 1) so whole frames and
// the vertical sync window fit in a short run.
module tb_vga_timing_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // default build
   logic       a_pe, a_hs, a_vs, a_von, a_fs;
   logic [9:0] a_h, a_v;
   logic [18:0] a_addr;
   // 16x12 raster, CLK_DIV=2
   logic       b_pe, b_hs, b_vs, b_von, b_fs;
   logic [9:0] b_h, b_v;
   logic [18:0] b_addr;
   // 16x12 raster, CLK_DIV=1
   logic       c_pe, c_hs, c_vs, c_von, c_fs;
   logic [9:0] c_h, c_v;
   logic [18:0] c_addr;

   vga_timing_gen u_a (
      .clk(clk), .rst_n(rst_n), .pix_en(a_pe), .H_Count_Value(a_h), .V_Count_Value(a_v),
      .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .pixel_addr(a_addr), .frame_start(a_fs)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .ADDR_W(19)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .pix_en(b_pe), .H_Count_Value(b_h), .V_Count_Value(b_v),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .pixel_addr(b_addr), .frame_start(b_fs)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .ADDR_W(19)
   ) u_c (
      .clk(clk), .rst_n(rst_n), .pix_en(c_pe), .H_Count_Value(c_h), .V_Count_Value(c_v),
      .hsync(c_hs), .vsync(c_vs), .video_on(c_von), .pixel_addr(c_addr), .frame_start(c_fs)
   );

   int n_vec = 0;
   int n_err = 0;
   int a_cnt, b_cnt, c_cnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      int h, v, hs, vs, von, addr, fs, pe;
   } exp_t;

   // Expected outputs after clock edge e following reset release (e=0 means
   // still in reset / no edge yet). The pixel enable is high after edges
   // d, 2d, ...; each high enable steps the raster on the next edge, so the
   // number of steps taken after edge e is (e-1)/d.
   function automatic exp_t model(input int e, input int d,
                                  input int ha, input int hfp, input int hsw, input int hbp,
                                  input int va, input int vfp, input int vsw, input int vbp);
      exp_t x;
      int ht = ha + hfp + hsw + hbp;
      int vt = va + vfp + vsw + vbp;
      int steps = (e >= 1) ? (e - 1) / d : 0;
      int p = steps % (ht * vt);
      x.h   = p % ht;
      x.v   = p / ht;
      x.pe  = (e >= 1 && (e % d) == 0) ? 1 : 0;
      x.hs  = (x.h >= ha + hfp && x.h < ha + hfp + hsw) ? 0 : 1;
      x.vs  = (x.v >= va + vfp && x.v < va + vfp + vsw) ? 0 : 1;
      x.von = (x.h < ha && x.v < va) ? 1 : 0;
      if (x.v >= va)      x.addr = va * ha;
      else if (x.h < ha)  x.addr = x.v * ha + x.h;
      else                x.addr = (x.v + 1) * ha;
      x.fs  = (e >= 2 && ((e - 1) % d) == 0 && steps > 0 && p == 0) ? 1 : 0;
      return x;
   endfunction

   task automatic chk_inst(input string nm, input exp_t x, input logic pe,
                           input logic [9:0] h, input logic [9:0] v, input logic hs,
                           input logic vs, input logic von, input logic [18:0] addr,
                           input logic fs);
      chk({nm, ".pix_en"},      32'(pe),   x.pe);
      chk({nm, ".H"},           32'(h),    x.h);
      chk({nm, ".V"},           32'(v),    x.v);
      chk({nm, ".hsync"},       32'(hs),   x.hs);
      chk({nm, ".vsync"},       32'(vs),   x.vs);
      chk({nm, ".video_on"},    32'(von),  x.von);
      chk({nm, ".pixel_addr"},  32'(addr), x.addr);
      chk({nm, ".frame_start"}, 32'(fs),   x.fs);
   endtask

   task automatic check_all(input int e);
      chk_inst("A", model(e, 2, 640, 16, 96, 48, 480, 10, 2, 33),
               a_pe, a_h, a_v, a_hs, a_vs, a_von, a_addr, a_fs);
      chk_inst("B", model(e, 2, 8, 2, 3, 3, 6, 2, 2, 2),
               b_pe, b_h, b_v, b_hs, b_vs, b_von, b_addr, b_fs);
      chk_inst("C", model(e, 1, 8, 2, 3, 3, 6, 2, 2, 2),
               c_pe, c_h, c_v, c_hs, c_vs, c_von, c_addr, c_fs);
   endtask

   // Hand-computed landmarks: edge = 1 + CLK_DIV*steps
   task automatic directed(input int e);
      case (e)
         1279: chk("A.von_h639",   32'(a_von), 1);
         1281: chk("A.von_h640",   32'(a_von), 0);
         1311: chk("A.hsync_h655", 32'(a_hs), 1);
         1313: chk("A.hsync_h656", 32'(a_hs), 0);
         1503: chk("A.hsync_h751", 32'(a_hs), 0);
         1505: chk("A.hsync_h752", 32'(a_hs), 1);
         1599: chk("A.h_799",      32'(a_h), 799);
         1601: begin
            chk("A.line_wrap_h",  32'(a_h), 0);
            chk("A.line_wrap_v",  32'(a_v), 1);
            chk("A.addr_line1",   32'(a_addr), 640);
         end
         175:  chk("B.addr_last_active", 32'(b_addr), 47);
         177:  chk("B.addr_blank_hold",  32'(b_addr), 48);
         255:  chk("B.vsync_v7",  32'(b_vs), 1);
         257:  chk("B.vsync_v8",  32'(b_vs), 0);
         289:  chk("B.vsync_v9",  32'(b_vs), 0);
         321:  chk("B.vsync_v10", 32'(b_vs), 1);
         385: begin
            chk("B.frame_wrap_fs",   32'(b_fs), 1);
            chk("B.frame_wrap_addr", 32'(b_addr), 0);
            chk("B.frame_wrap_hv",   32'({b_h, b_v}), 0);
         end
         193:  chk("C.frame_wrap_fs", 32'(c_fs), 1);
         default: ;
      endcase
   endtask

   task automatic run(input int n);
      int bl = 0;
      int cl = 0;
      a_cnt = 0; b_cnt = 0; c_cnt = 0;
      for (int e = 1; e <= n; e++) begin
         @(posedge clk);
         @(negedge clk);
         check_all(e);
         directed(e);
         if (a_fs) a_cnt++;
         if (b_fs) begin
            if (bl > 0) chk("B.frame_period", 32'(e - bl), 384);
            bl = e;
            b_cnt++;
         end
         if (c_fs) begin
            if (cl > 0) chk("C.frame_period", 32'(e - cl), 192);
            cl = e;
            c_cnt++;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all(0);
      rst_n = 1'b1;

      run(1700);
      chk("A.fs_count", 32'(a_cnt), 0);
      chk("B.fs_count", 32'(b_cnt), 4);
      chk("C.fs_count", 32'(c_cnt), 8);

      // Mid-pixel asynchronous reset: outputs must clear without a clock edge
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all(0);
      @(negedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all(0);
      rst_n = 1'b1;

      // Restart must replay power-up timing exactly
      run(700);
      chk("B.fs_count_rerun", 32'(b_cnt), 1);
      chk("C.fs_count_rerun", 32'(c_cnt), 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
